fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register ahead of the decode/control stage.
//  - Owns the PC and drives the instruction-memory address.
//  - Redirects the PC on taken branches/jumps resolved downstream.
//  - Registers the fetched word, its PC and a valid bit for decode.
//  - op_id (instr_id[31:25]) feeds the control decoder directly. Squashed slots carry opcode 7'h00 (NOP).

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the instruction memory (slave).
// Address and read strobe go out; the word and its ready flag come back combinationally.
interface fetch_stage_if #(
    parameter int AW = 32,
    parameter int IW = 32
);
    logic [AW-1:0] imem_addr;
    logic          imem_rd;
    logic [IW-1:0] imem_data;
    logic          imem_rdy;

    modport master (
        output imem_addr,
        output imem_rd,
        input  imem_data,
        input  imem_rdy
    );

    modport slave (
        input  imem_addr,
        input  imem_rd,
        output imem_data,
        output imem_rdy
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from imem and fills the IF/ID pipeline register.
// Optional FETCH_PERF_EN adds saturating stall/flush/bubble event counters.
module fetch_stage #(
    parameter int            AW       = 32,
    parameter int            IW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    fetch_stage_if.master imem,
    output logic [IW-1:0] instr_id,
    output logic [6:0]    op_id,
    output logic [AW-1:0] pc_id,
    output logic [AW-1:0] pc4_id,
    output logic          valid_id
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_stall,
    output logic [31:0]   perf_flush,
    output logic [31:0]   perf_bubble
`endif
);

    localparam logic [AW-1:0] PC_STEP = {{(AW-3){1'b0}}, 3'b100};

    logic [AW-1:0] pc;

    assign imem.imem_addr = pc;
    assign imem.imem_rd   = ~rst & ~stall & ~br_taken;
    assign op_id          = instr_id[IW-1:IW-7];
    assign pc4_id         = pc_id + PC_STEP;

    // PC and IF/ID register update, priority rst > br_taken > stall > fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= {RESET_PC[AW-1:2], 2'b00};
            instr_id <= {IW{1'b0}};
            pc_id    <= {AW{1'b0}};
            valid_id <= 1'b0;
        end else if (br_taken) begin
            // Redirect: the word on the bus belongs to the wrong path, so squash it
            pc       <= {br_target[AW-1:2], 2'b00};
            instr_id <= {IW{1'b0}};
            valid_id <= 1'b0;
        end else if (stall) begin
            pc       <= pc;
            instr_id <= instr_id;
            pc_id    <= pc_id;
            valid_id <= valid_id;
        end else if (imem.imem_rdy) begin
            instr_id <= imem.imem_data;
            pc_id    <= pc;
            valid_id <= 1'b1;
            pc       <= pc + PC_STEP;
        end else begin
            // Memory not ready: issue a bubble and refetch the same PC
            instr_id <= {IW{1'b0}};
            valid_id <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Saturating event counters, cleared and frozen while rst is high
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall  <= 32'd0;
            perf_flush  <= 32'd0;
            perf_bubble <= 32'd0;
        end else if (br_taken) begin
            if (perf_flush != CNT_MAX) begin
                perf_flush <= perf_flush + 32'd1;
            end
        end else if (stall) begin
            if (perf_stall != CNT_MAX) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end else if (!imem.imem_rdy) begin
            if (perf_bubble != CNT_MAX) begin
                perf_bubble <= perf_bubble + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; build with +define+FETCH_PERF_EN to cover the counters.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst, stall, br_taken, rdy;
    logic [31:0] br_target;
    logic [31:0] instr_id, pc_id, pc4_id;
    logic [6:0]  op_id;
    logic        valid_id;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall, perf_flush, perf_bubble;
`endif
    int checks = 0;
    int errors = 0;

    fetch_stage_if #(.AW(32), .IW(32)) bus ();

    // Memory contents: distinct, nonzero-opcode word per address
    function automatic logic [31:0] word(input logic [31:0] a);
        return ~a ^ 32'h1234_5678;
    endfunction

    assign bus.imem_data = word(bus.imem_addr);
    assign bus.imem_rdy  = rdy;

    fetch_stage #(.AW(32), .IW(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .imem(bus.master), .instr_id(instr_id), .op_id(op_id), .pc_id(pc_id),
        .pc4_id(pc4_id), .valid_id(valid_id)
`ifdef FETCH_PERF_EN
        , .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_bubble(perf_bubble)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; rdy = 1'b1;
        step(); step();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", bus.imem_addr, 32'h0); end
        checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_id); end
        checks++; if (instr_id !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr_id); end
        checks++; if (pc4_id !== 32'h4) begin errors++; $display("FAIL rst_pc4 got %h exp 4", pc4_id); end
        checks++; if (bus.imem_rd !== 1'b0) begin errors++; $display("FAIL rst_rd got %b exp 0", bus.imem_rd); end
        rst = 1'b0; #1;
        checks++; if (bus.imem_rd !== 1'b1) begin errors++; $display("FAIL run_rd got %b exp 1", bus.imem_rd); end
    endtask

    task automatic test_fetch();
        step();
        checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL f1_pc got %h exp 4", bus.imem_addr); end
        checks++; if (instr_id !== word(32'h0)) begin errors++; $display("FAIL f1_instr got %h exp %h", instr_id, word(32'h0)); end
        checks++; if (pc_id !== 32'h0 || valid_id !== 1'b1) begin errors++; $display("FAIL f1_pcid got %h/%b exp 0/1", pc_id, valid_id); end
        checks++; if (op_id !== word(32'h0) >> 25) begin errors++; $display("FAIL f1_op got %h exp %h", op_id, word(32'h0) >> 25); end
        step();
        checks++; if (instr_id !== word(32'h4) || bus.imem_addr !== 32'h8) begin errors++; $display("FAIL f2 got %h pc %h", instr_id, bus.imem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1; #1;
        checks++; if (bus.imem_rd !== 1'b0) begin errors++; $display("FAIL stall_rd got %b exp 0", bus.imem_rd); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (instr_id !== word(32'h4) || pc_id !== 32'h4 || bus.imem_addr !== 32'h8) begin
                errors++; $display("FAIL stall_hold%0d got %h/%h/%h", i, instr_id, pc_id, bus.imem_addr);
            end
        end
        stall = 1'b0;
        step();
        checks++; if (instr_id !== word(32'h8) || pc_id !== 32'h8 || bus.imem_addr !== 32'hC) begin errors++; $display("FAIL stall_rel got %h/%h/%h", instr_id, pc_id, bus.imem_addr); end
    endtask

    task automatic test_redirect();
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h40;
        step();
        checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL br_pc got %h exp 40", bus.imem_addr); end
        checks++; if (valid_id !== 1'b0 || op_id !== 7'h0 || instr_id !== 32'h0) begin errors++; $display("FAIL br_bubble got %b/%h/%h", valid_id, op_id, instr_id); end
        checks++; if (pc_id !== 32'h8) begin errors++; $display("FAIL br_pcid_hold got %h exp 8", pc_id); end
        stall = 1'b0; br_taken = 1'b0;
        step();
        checks++; if (instr_id !== word(32'h40) || pc_id !== 32'h40 || valid_id !== 1'b1) begin errors++; $display("FAIL br_tgt got %h/%h/%b", instr_id, pc_id, valid_id); end
    endtask

    task automatic test_rdy_low();
        br_taken = 1'b1; br_target = 32'h10;
        step();
        br_taken = 1'b0; rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (valid_id !== 1'b0 || instr_id !== 32'h0 || bus.imem_addr !== 32'h10) begin
                errors++; $display("FAIL rdy_bubble%0d got %b/%h/%h", i, valid_id, instr_id, bus.imem_addr);
            end
        end
        rdy = 1'b1;
        step();
        checks++; if (pc_id !== 32'h10 || valid_id !== 1'b1 || instr_id !== word(32'h10)) begin errors++; $display("FAIL rdy_ok got %h/%b/%h", pc_id, valid_id, instr_id); end
    endtask

    task automatic test_back_to_back();
        br_taken = 1'b1; br_target = 32'h100;
        step();
        checks++; if (bus.imem_addr !== 32'h100 || valid_id !== 1'b0) begin errors++; $display("FAIL b2b_1 got %h/%b", bus.imem_addr, valid_id); end
        br_target = 32'h202;
        step();
        checks++; if (bus.imem_addr !== 32'h200 || valid_id !== 1'b0) begin errors++; $display("FAIL b2b_2 got %h/%b", bus.imem_addr, valid_id); end
        br_taken = 1'b0;
        step();
        checks++; if (pc_id !== 32'h200 || instr_id !== word(32'h200)) begin errors++; $display("FAIL b2b_tgt got %h/%h", pc_id, instr_id); end
    endtask

    task automatic test_wrap();
        br_taken = 1'b1; br_target = 32'hFFFF_FFFD;
        step();
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align got %h exp fffffffc", bus.imem_addr); end
        br_taken = 1'b0;
        step();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", bus.imem_addr); end
        checks++; if (pc_id !== 32'hFFFF_FFFC || pc4_id !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h/%h", pc_id, pc4_id); end
    endtask

    task automatic test_reset_mid_stall();
        br_taken = 1'b1; br_target = 32'h20;
        step();
        br_taken = 1'b0;
        step();
        stall = 1'b1;
        step();
        checks++; if (valid_id !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got %b exp 1", valid_id); end
        rst = 1'b1;
        step();
        checks++; if (bus.imem_addr !== 32'h0 || valid_id !== 1'b0 || pc_id !== 32'h0) begin errors++; $display("FAIL rst_stall got %h/%b/%h", bus.imem_addr, valid_id, pc_id); end
`ifdef FETCH_PERF_EN
        checks++; if (perf_stall !== 32'd0 || perf_flush !== 32'd0 || perf_bubble !== 32'd0) begin errors++; $display("FAIL perf_clr got %0d/%0d/%0d", perf_stall, perf_flush, perf_bubble); end
`endif
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++; if (bus.imem_addr !== 32'h0 || valid_id !== 1'b0) begin errors++; $display("FAIL post_rst_stall got %h/%b", bus.imem_addr, valid_id); end
`ifdef FETCH_PERF_EN
        checks++; if (perf_stall !== 32'd3) begin errors++; $display("FAIL perf_stall got %0d exp 3", perf_stall); end
        stall = 1'b0; br_taken = 1'b1; br_target = 32'h0;
        step();
        br_taken = 1'b0; rdy = 1'b0;
        step();
        checks++; if (perf_flush !== 32'd1 || perf_bubble !== 32'd1 || perf_stall !== 32'd3) begin errors++; $display("FAIL perf_cnt got %0d/%0d/%0d", perf_stall, perf_flush, perf_bubble); end
        rdy = 1'b1;
`endif
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_rdy_low();
        test_back_to_back();
        test_wrap();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
